btn_event_decoder: RTL and testbench



---
 rtl/btn_event_decoder.sv | 173 +++++++++++++++++
 tb/tb_btn_event_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// Decodes the button generator's pulse bursts into click / double-click / long-press strobes.
// A framer validates burst shape; a classifier times the press and release windows.
//
//   state   | meaning
//   F_IDLE  | waiting for the first high of a burst
//   F_GAP   | last sample was high, a low is expected
//   F_HIGH  | last sample was low inside a burst, a high is expected
//   C_IDLE  | no press in progress
//   C_PRESS | valid burst seen, timing how long the button is held
//   C_HOLD  | event already reported, waiting for release
//   C_WAIT  | released, watching for a second burst within the double window
module btn_event_decoder #(
   parameter int BURST_LEN     = 3,
   parameter int DOUBLE_WINDOW = 25000000,
   parameter int LONG_PERIOD   = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pulse_in,
   input  logic       level_in,
   output logic       single_click,
   output logic       double_click,
   output logic       long_press,
   output logic       burst_err,
   output logic [7:0] event_count,
   output logic       busy
);

   typedef enum logic [1:0] {F_IDLE, F_GAP, F_HIGH} fstate_t;
   typedef enum logic [1:0] {C_IDLE, C_PRESS, C_HOLD, C_WAIT} cstate_t;

   localparam logic [2:0]  BL      = 3'(BURST_LEN);
   localparam logic [31:0] LP_LAST = 32'(LONG_PERIOD - 1);
   localparam logic [31:0] DW_LAST = 32'(DOUBLE_WINDOW - 1);

   fstate_t     f_q, f_d;
   cstate_t     c_q, c_d;
   logic [2:0]  pc_q, pc_d;
   logic [31:0] t_q, t_d, t_inc;
   logic        ok_q, ok_d;
   logic        err_q, err_d;
   logic        sc_q, sc_d, dc_q, dc_d, lp_q, lp_d;
   logic [7:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q   <= F_IDLE;
         c_q   <= C_IDLE;
         pc_q  <= 3'd0;
         t_q   <= 32'd0;
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         sc_q  <= 1'b0;
         dc_q  <= 1'b0;
         lp_q  <= 1'b0;
         cnt_q <= 8'd0;
      end else begin
         f_q   <= f_d;
         c_q   <= c_d;
         pc_q  <= pc_d;
         t_q   <= t_d;
         ok_q  <= ok_d;
         err_q <= err_d;
         sc_q  <= sc_d;
         dc_q  <= dc_d;
         lp_q  <= lp_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      f_d   = f_q;
      pc_d  = pc_q;
      ok_d  = 1'b0;
      err_d = 1'b0;
      case (f_q)
         F_IDLE: begin
            if (pulse_in) begin
               pc_d = 3'd1;
               f_d  = F_GAP;
            end
         end
         F_GAP: begin
            if (pulse_in) begin
               err_d = 1'b1;
               pc_d  = 3'd0;
               f_d   = F_IDLE;
            end else if (pc_q == BL) begin
               ok_d = 1'b1;
               pc_d = 3'd0;
               f_d  = F_IDLE;
            end else begin
               f_d = F_HIGH;
            end
         end
         F_HIGH: begin
            if (pulse_in) begin
               pc_d = pc_q + 3'd1;
               f_d  = F_GAP;
            end else begin
               err_d = 1'b1;
               pc_d  = 3'd0;
               f_d   = F_IDLE;
            end
         end
         default: begin
            pc_d = 3'd0;
            f_d  = F_IDLE;
         end
      endcase
   end

   // Timeouts fire on the edge where the incremented timer hits its last value.
   always_comb begin
      c_d   = c_q;
      t_d   = t_q;
      sc_d  = 1'b0;
      dc_d  = 1'b0;
      lp_d  = 1'b0;
      t_inc = t_q + 32'd1;
      case (c_q)
         C_IDLE: begin
            if (ok_q) begin
               t_d = 32'd0;
               c_d = C_PRESS;
            end
         end
         C_PRESS: begin
            if (level_in) begin
               t_d = t_inc;
               if (t_inc == LP_LAST) begin
                  lp_d = 1'b1;
                  t_d  = 32'd0;
                  c_d  = C_HOLD;
               end
            end else begin
               t_d = 32'd0;
               c_d = C_WAIT;
            end
         end
         C_HOLD: begin
            if (!level_in) c_d = C_IDLE;
         end
         C_WAIT: begin
            if (ok_q) begin
               dc_d = 1'b1;
               t_d  = 32'd0;
               c_d  = C_HOLD;
            end else begin
               t_d = t_inc;
               if (t_inc == DW_LAST) begin
                  sc_d = 1'b1;
                  t_d  = 32'd0;
                  c_d  = C_IDLE;
               end
            end
         end
         default: begin
            t_d = 32'd0;
            c_d = C_IDLE;
         end
      endcase
      cnt_d = cnt_q + {7'd0, (sc_d | dc_d | lp_d)};
   end

   assign single_click = sc_q;
   assign double_click = dc_q;
   assign long_press   = lp_q;
   assign burst_err    = err_q;
   assign event_count  = cnt_q;
   assign busy         = (c_q != C_IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with short windows (BURST_LEN=3, DOUBLE_WINDOW=20, LONG_PERIOD=30).
module tb_btn_event_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pulse_in = 1'b0;
   logic       level_in = 1'b0;
   logic       single_click, double_click, long_press, burst_err, busy;
   logic [7:0] event_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int sc_n  = 0;
   int dc_n  = 0;
   int lp_n  = 0;
   int err_n = 0;
   int sc_snap;

   btn_event_decoder #(
      .BURST_LEN(3),
      .DOUBLE_WINDOW(20),
      .LONG_PERIOD(30)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pulse_in(pulse_in),
      .level_in(level_in),
      .single_click(single_click),
      .double_click(double_click),
      .long_press(long_press),
      .burst_err(burst_err),
      .event_count(event_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: wait for the edge, settle, then tally any strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (single_click) sc_n++;
      if (double_click) dc_n++;
      if (long_press)   lp_n++;
      if (burst_err)    err_n++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Valid burst 1,0,1,0,1,0; burst_ok is high right after the last tick.
   task automatic burst();
      for (int i = 0; i < 6; i++) begin
         pulse_in = (i % 2 == 0);
         tick();
      end
      pulse_in = 1'b0;
   endtask

   // Short press followed by release; single_click expected 20 cycles after release.
   task automatic click_and_release();
      level_in = 1'b1;
      burst();
      tick();
      level_in = 1'b0;
      run(20);
   endtask

   initial begin
      // reset state
      run(2);
      check("rst_single", single_click, 0);
      check("rst_count", event_count, 0);
      check("rst_busy", busy, 0);
      check("rst_err", burst_err, 0);
      rst_n = 1'b1;
      run(2);

      // single click
      level_in = 1'b1;
      burst();
      run(4);
      check("sc_press_busy", busy, 1);
      level_in = 1'b0;
      run(19);
      check("sc_early", sc_n, 0);
      check("sc_wait_busy", busy, 1);
      run(1);
      check("sc_strobe", single_click, 1);
      check("sc_count", event_count, 1);
      run(1);
      check("sc_strobe_low", single_click, 0);
      check("sc_busy_after", busy, 0);

      // double click: second burst_ok 10 cycles after release
      level_in = 1'b1;
      burst();
      run(3);
      level_in = 1'b0;
      run(4);
      level_in = 1'b1;
      burst();
      tick();
      check("dc_strobe", double_click, 1);
      check("dc_count", event_count, 2);
      run(5);
      check("dc_hold_busy", busy, 1);
      level_in = 1'b0;
      tick();
      check("dc_busy_after", busy, 0);
      check("dc_total", dc_n, 1);
      check("dc_no_single", sc_n, 1);

      // long press: strobe 30 cycles after burst_ok
      level_in = 1'b1;
      burst();
      run(29);
      check("lp_early", lp_n, 0);
      run(1);
      check("lp_strobe", long_press, 1);
      check("lp_count", event_count, 3);
      run(9);
      check("lp_once", lp_n, 1);
      check("lp_hold_busy", busy, 1);
      level_in = 1'b0;
      tick();
      check("lp_busy_after", busy, 0);
      check("lp_no_single", sc_n, 1);

      // malformed bursts
      pulse_in = 1'b1;
      tick();
      tick();
      check("err_hh", burst_err, 1);
      pulse_in = 1'b0;
      tick();
      check("err_hh_low", burst_err, 0);
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      tick();
      tick();
      check("err_hll", burst_err, 1);
      tick();
      check("err_total", err_n, 2);
      check("err_count", event_count, 3);
      check("err_busy", busy, 0);
      click_and_release();
      check("err_then_valid", single_click, 1);
      check("err_then_count", event_count, 4);
      tick();

      // window expiry then a fresh press
      click_and_release();
      check("exp_first", single_click, 1);
      check("exp_count1", event_count, 5);
      level_in = 1'b1;
      burst();
      tick();
      check("exp_new_press", busy, 1);
      level_in = 1'b0;
      run(20);
      check("exp_second", single_click, 1);
      check("exp_count2", event_count, 6);
      check("exp_no_double", dc_n, 1);
      tick();

      // reset during C_WAIT
      level_in = 1'b1;
      burst();
      tick();
      level_in = 1'b0;
      run(5);
      sc_snap = sc_n;
      rst_n = 1'b0;
      #1;
      check("rst_mid_count", event_count, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_single", single_click, 0);
      run(3);
      rst_n = 1'b1;
      run(25);
      check("rst_no_single", sc_n, sc_snap);
      check("rst_idle", busy, 0);

      // counter wrap
      for (int i = 0; i < 255; i++) click_and_release();
      check("wrap_255", event_count, 255);
      click_and_release();
      check("wrap_0", event_count, 0);
      check("wrap_singles", sc_n, sc_snap + 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
